// File: rtl/dec_ascii_pkg.sv
// dec_ascii_pkg: FSM states, ASCII constants and decimal digit-count helper for dec_ascii_fmt
package dec_ascii_pkg;
  typedef enum logic [2:0] {IDLE, CONV, SCAN, DIG, CR, LF} state_t;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  function automatic int clog10_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble, one bit per cycle after start; done stays high from the cycle after the last shift until the next start (clk, rst_n, start, bin -> done, bcd)
module bin2bcd_serial #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic run;
  logic [4*DIGITS-1:0] adj;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g+:4] = bcd[4*g+:4] >= 4'd5 ? bcd[4*g+:4] + 4'd3 : bcd[4*g+:4];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      run <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
    end else if (start) begin
      sr <= bin;
      cnt <= CW'(DATA_W - 1);
      run <= 1'b1;
      done <= 1'b0;
      bcd <= '0;
    end else if (run) begin
      bcd <= {adj[4*DIGITS-2:0], sr[DATA_W-1]};
      sr <= sr << 1;
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
      done <= cnt == '0;
    end
endmodule

// File: rtl/dec_ascii_fmt.sv
// dec_ascii_fmt: unsigned word -> decimal ASCII line byte stream (in_data/in_valid/in_ready -> out_byte/out_valid/out_ready/out_last, busy)
module dec_ascii_fmt
  import dec_ascii_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10,
  parameter bit EOL_CRLF = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);
  if (DIGITS < clog10_digits(DATA_W)) begin : g_digits_chk
    $error("dec_ascii_fmt: DIGITS too small for DATA_W");
  end
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, nxt;
  logic armed, conv_done, start, xfer;
  logic [4*DIGITS-1:0] bcd;
  logic [IW-1:0] idx, msd;
  logic [3:0] dig;
  assign start = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  assign dig = bcd[4*idx+:4];
  bin2bcd_serial #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_b2b (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bin(in_data),
    .done(conv_done),
    .bcd(bcd)
  );
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) msd = bcd[4*i+:4] != 4'd0 ? IW'(i) : msd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      idx <= '0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      idx <= state == SCAN ? msd : (state == DIG && xfer && idx != '0) ? idx - 1'b1 : idx;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? CONV : IDLE;
      CONV: nxt = conv_done ? SCAN : CONV;
      SCAN: nxt = DIG;
      DIG:  nxt = (xfer && idx == '0) ? (EOL_CRLF ? CR : LF) : DIG;
      CR:   nxt = xfer ? LF : CR;
      LF:   nxt = xfer ? IDLE : LF;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE && armed;
    busy = state != IDLE;
    out_valid = state == DIG || state == CR || state == LF;
    out_last = state == LF;
    out_byte = state == DIG ? ASCII_ZERO + {4'd0, dig} : state == CR ? ASCII_CR : state == LF ? ASCII_LF : 8'h00;
  end
endmodule
